// File: rtl/hyperram_port_arbiter.sv
// HyperRAM port arbiter.
// Hands the single HyperRAM port to one of two masters at a time: requester 0
// (frame capture writer) or requester 1 (frame upload reader). Ties are broken
// round-robin, a CE-high turnaround gap separates consecutive owners, and a
// watchdog takes the port back from an owner that never finishes.
module hyperram_port_arbiter #(
    parameter int TURN_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iEn,
    input  logic iReq0,
    input  logic iDone0,
    output logic oGnt0,
    input  logic iReq1,
    input  logic iDone1,
    output logic oGnt1,
    output logic oRAM_Sel,
    output logic oBusy,
    output logic oTimeout
);

    // A zero timeout turns the watchdog off; keep the counter at least 1 bit wide.
    localparam bit WD_ON = (TIMEOUT_CYCLES > 0);
    localparam int WD_W  = WD_ON ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int GAP_W = $clog2(TURN_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_ON ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t            state_reg;
    logic              gnt0_reg;
    logic              gnt1_reg;
    logic              sel_reg;
    logic              busy_reg;
    logic              timeout_reg;
    logic              last_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [WD_W-1:0]   wd_cnt_reg;

    logic [1:0] req_vec;
    logic [1:0] done_vec;
    logic [1:0] release_vec;
    logic       pick;
    logic       owner_idx;
    logic       release_now;
    logic       wd_expire;

    assign req_vec  = {iReq1, iReq0};
    assign done_vec = {iDone1, iDone0};

    // An owner gives the port back either by finishing or by dropping its request.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_release
            assign release_vec[gi] = done_vec[gi] | ~req_vec[gi];
        end
    endgenerate

    // With both requesting, the one that did not own the port last time wins;
    // a lone requester always wins, even if it was the previous owner.
    assign pick        = (iReq0 && iReq1) ? ~last_reg : iReq1;
    assign owner_idx   = (state_reg == GRANT1);
    assign release_now = release_vec[owner_idx];
    assign wd_expire   = WD_ON && (wd_cnt_reg == WD_LAST);

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg   <= IDLE;
            gnt0_reg    <= 1'b0;
            gnt1_reg    <= 1'b0;
            sel_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            last_reg    <= 1'b1;
            gap_cnt_reg <= '0;
            wd_cnt_reg  <= '0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (iEn && (iReq0 || iReq1)) begin
                        state_reg  <= pick ? GRANT1 : GRANT0;
                        gnt0_reg   <= ~pick;
                        gnt1_reg   <= pick;
                        sel_reg    <= pick;
                        last_reg   <= pick;
                        busy_reg   <= 1'b1;
                        wd_cnt_reg <= '0;
                    end
                end
                GRANT0, GRANT1: begin
                    // A finishing owner on the final allowed cycle beats the watchdog.
                    if (release_now || wd_expire) begin
                        state_reg   <= GAP;
                        gnt0_reg    <= 1'b0;
                        gnt1_reg    <= 1'b0;
                        gap_cnt_reg <= '0;
                        timeout_reg <= ~release_now;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    // Select stays on the last owner so its idle CE level holds the pins.
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt0_reg  <= 1'b0;
                    gnt1_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign oGnt0    = gnt0_reg;
    assign oGnt1    = gnt1_reg;
    assign oRAM_Sel = sel_reg;
    assign oBusy    = busy_reg;
    assign oTimeout = timeout_reg;

endmodule

// File: tb/tb_hyperram_port_arbiter.sv
// Bench for hyperram_port_arbiter: scenario tasks push the grant each one
// expects; a negedge monitor pops and compares every grant when it ends.
module tb_hyperram_port_arbiter;

    localparam int TURN = 4;
    localparam int TMO  = 16;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    logic iEn = 1'b0;
    logic iReq0 = 1'b0, iDone0 = 1'b0, iReq1 = 1'b0, iDone1 = 1'b0;
    logic oGnt0, oGnt1, oRAM_Sel, oBusy, oTimeout;

    hyperram_port_arbiter #(.TURN_CYCLES(TURN), .TIMEOUT_CYCLES(TMO)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn),
        .iReq0(iReq0), .iDone0(iDone0), .oGnt0(oGnt0),
        .iReq1(iReq1), .iDone1(iDone1), .oGnt1(oGnt1),
        .oRAM_Sel(oRAM_Sel), .oBusy(oBusy), .oTimeout(oTimeout)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int owner;
        int start;
        int len;
        bit to;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    bit  sb_en = 1'b1;
    bit  excl_en = 1'b0;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    function automatic ev_t mk(input int o, input int s, input int l, input bit t);
        ev_t e;
        e.owner = o; e.start = s; e.len = l; e.to = t;
        return e;
    endfunction

    // Grant monitor: on each grant falling edge, compare against the oldest expectation.
    initial begin : monitor
        logic p0, p1, g, p;
        int   st0, st1, st;
        ev_t  e;
        p0 = 1'b0; p1 = 1'b0; st0 = 0; st1 = 0;
        forever begin
            @(negedge iClk);
            if (oGnt0 && !p0) st0 = cyc;
            if (oGnt1 && !p1) st1 = cyc;
            for (int o = 0; o < 2; o++) begin
                g  = (o == 1) ? oGnt1 : oGnt0;
                p  = (o == 1) ? p1 : p0;
                st = (o == 1) ? st1 : st0;
                if (sb_en && p && !g) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected got owner=%0d start=%0d len=%0d to=%0d required=no grant",
                                 o, st, cyc - st, oTimeout);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.owner !== o || e.start !== st || e.len !== cyc - st || e.to !== oTimeout) begin
                            errors++;
                            $display("FAIL sb_grant got owner=%0d start=%0d len=%0d to=%0d required owner=%0d start=%0d len=%0d to=%0d",
                                     o, st, cyc - st, oTimeout, e.owner, e.start, e.len, e.to);
                        end else begin
                            $display("grant owner=%0d start=%0d len=%0d timeout=%0d ok", o, st, cyc - st, oTimeout);
                        end
                    end
                end
            end
            if (excl_en) begin
                checks++;
                if ((oGnt0 && oGnt1) || (oGnt0 && oRAM_Sel) || (oGnt1 && !oRAM_Sel)) begin
                    errors++;
                    $display("FAIL excl got gnt0=%b gnt1=%b sel=%b required one grant with matching sel",
                             oGnt0, oGnt1, oRAM_Sel);
                end
            end
            p0 = oGnt0;
            p1 = oGnt1;
        end
    end

    task automatic do_reset();
        iRst = 1'b1;
        tick(2);
        iRst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        iRst = 1'b1; iEn = 1'b0;
        tick(3);
        checks++; if (oGnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0 got=%b required=0", oGnt0); end
        checks++; if (oGnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1 got=%b required=0", oGnt1); end
        checks++; if (oRAM_Sel !== 1'b0) begin errors++; $display("FAIL reset_sel got=%b required=0", oRAM_Sel); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", oBusy); end
        checks++; if (oTimeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b required=0", oTimeout); end
        iRst = 1'b0;
        tick(1);
        $display("test_reset done");
    endtask

    task automatic test_single();
        int c;
        iEn = 1'b1;
        c = cyc;
        iReq0 = 1'b1;
        exp_q.push_back(mk(0, c + 1, 10, 1'b0));
        tick(1);
        checks++; if (oGnt0 !== 1'b1) begin errors++; $display("FAIL single_gnt0 got=%b required=1", oGnt0); end
        checks++; if (oRAM_Sel !== 1'b0) begin errors++; $display("FAIL single_sel got=%b required=0", oRAM_Sel); end
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b required=1", oBusy); end
        tick(9);
        iDone0 = 1'b1; iReq0 = 1'b0;
        tick(1);
        iDone0 = 1'b0;
        checks++; if (oGnt0 !== 1'b0) begin errors++; $display("FAIL single_release got=%b required=0", oGnt0); end
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL single_gap_busy got=%b required=1", oBusy); end
        tick(3);
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL single_gap_end_busy got=%b required=1", oBusy); end
        tick(1);
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b required=0", oBusy); end
        tick(2);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing got=%0d pending required=0", exp_q.size()); end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        int c, s, o;
        do_reset();
        iEn = 1'b1;
        c = cyc;
        s = c + 1;
        iReq0 = 1'b1; iReq1 = 1'b1;
        for (int r = 0; r < 5; r++) begin
            o = r % 2;
            exp_q.push_back(mk(o, s, 3, 1'b0));
            tick(1);
            checks++;
            if ({oGnt1, oGnt0} !== ((o == 1) ? 2'b10 : 2'b01) || oRAM_Sel !== 1'(o)) begin
                errors++;
                $display("FAIL rr_owner round=%0d got gnt1=%b gnt0=%b sel=%b required owner=%0d", r, oGnt1, oGnt0, oRAM_Sel, o);
            end
            tick(2);
            if (o == 1) iDone1 = 1'b1; else iDone0 = 1'b1;
            tick(1);
            iDone0 = 1'b0; iDone1 = 1'b0;
            checks++;
            if (oGnt0 !== 1'b0 || oGnt1 !== 1'b0 || oRAM_Sel !== 1'(o)) begin
                errors++;
                $display("FAIL rr_gap round=%0d got gnt1=%b gnt0=%b sel=%b required 0 0 sel=%0d", r, oGnt1, oGnt0, oRAM_Sel, o);
            end
            tick(4);
            s = s + 8;
        end
        iReq0 = 1'b0; iReq1 = 1'b0;
        tick(3);
        checks++; if (oGnt0 !== 1'b0 || oGnt1 !== 1'b0) begin errors++; $display("FAIL rr_end got gnt1=%b gnt0=%b required 0 0", oGnt1, oGnt0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_missing got=%0d pending required=0", exp_q.size()); end
        $display("test_round_robin done");
    endtask

    task automatic test_watchdog();
        int c;
        c = cyc;
        iReq1 = 1'b1;
        exp_q.push_back(mk(1, c + 1, TMO, 1'b1));
        exp_q.push_back(mk(1, c + 22, TMO, 1'b0));
        tick(16);
        checks++; if (oGnt1 !== 1'b1 || oTimeout !== 1'b0) begin errors++; $display("FAIL wd_last_cycle got gnt1=%b to=%b required 1 0", oGnt1, oTimeout); end
        tick(1);
        checks++; if (oGnt1 !== 1'b0 || oTimeout !== 1'b1) begin errors++; $display("FAIL wd_revoke got gnt1=%b to=%b required 0 1", oGnt1, oTimeout); end
        tick(1);
        checks++; if (oTimeout !== 1'b0 || oBusy !== 1'b1) begin errors++; $display("FAIL wd_pulse got to=%b busy=%b required 0 1", oTimeout, oBusy); end
        tick(19);
        checks++; if (oGnt1 !== 1'b1) begin errors++; $display("FAIL wd_regrant got gnt1=%b required 1", oGnt1); end
        iDone1 = 1'b1; iReq1 = 1'b0;
        tick(1);
        iDone1 = 1'b0;
        checks++; if (oGnt1 !== 1'b0 || oTimeout !== 1'b0) begin errors++; $display("FAIL wd_done_wins got gnt1=%b to=%b required 0 0", oGnt1, oTimeout); end
        tick(6);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wd_missing got=%0d pending required=0", exp_q.size()); end
        $display("test_watchdog done");
    endtask

    task automatic test_enable();
        int c;
        iEn = 1'b0;
        iReq0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            checks++;
            if (oGnt0 !== 1'b0 || oBusy !== 1'b0) begin errors++; $display("FAIL en_block cyc=%0d got gnt0=%b busy=%b required 0 0", i, oGnt0, oBusy); end
        end
        iReq0 = 1'b0; iEn = 1'b1;
        tick(1);
        c = cyc;
        iReq1 = 1'b1;
        exp_q.push_back(mk(1, c + 1, 5, 1'b0));
        tick(1);
        iEn = 1'b0;
        tick(3);
        checks++; if (oGnt1 !== 1'b1) begin errors++; $display("FAIL en_hold got gnt1=%b required 1", oGnt1); end
        tick(1);
        iDone1 = 1'b1; iReq1 = 1'b0;
        tick(1);
        iDone1 = 1'b0;
        checks++; if (oGnt1 !== 1'b0) begin errors++; $display("FAIL en_release got gnt1=%b required 0", oGnt1); end
        tick(4);
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL en_gap_end got busy=%b required 0", oBusy); end
        iEn = 1'b1;
        tick(1);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL en_missing got=%0d pending required=0", exp_q.size()); end
        $display("test_enable done");
    endtask

    task automatic test_abandon();
        int c;
        c = cyc;
        iReq0 = 1'b1;
        exp_q.push_back(mk(0, c + 1, 4, 1'b0));
        tick(2);
        iDone1 = 1'b1;
        tick(1);
        iDone1 = 1'b0;
        checks++; if (oGnt0 !== 1'b1) begin errors++; $display("FAIL ab_foreign_done got gnt0=%b required 1", oGnt0); end
        tick(1);
        iReq0 = 1'b0;
        tick(1);
        checks++; if (oGnt0 !== 1'b0 || oBusy !== 1'b1 || oTimeout !== 1'b0) begin
            errors++; $display("FAIL ab_release got gnt0=%b busy=%b to=%b required 0 1 0", oGnt0, oBusy, oTimeout);
        end
        tick(5);
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL ab_idle got busy=%b required 0", oBusy); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ab_missing got=%0d pending required=0", exp_q.size()); end
        $display("test_abandon done");
    endtask

    task automatic test_reset_mid_grant();
        int c;
        c = cyc;
        iReq1 = 1'b1;
        exp_q.push_back(mk(1, c + 1, 3, 1'b0));
        tick(1);
        checks++; if (oGnt1 !== 1'b1 || oRAM_Sel !== 1'b1) begin errors++; $display("FAIL rst_pre got gnt1=%b sel=%b required 1 1", oGnt1, oRAM_Sel); end
        tick(2);
        iRst = 1'b1;
        tick(1);
        checks++; if (oGnt1 !== 1'b0 || oRAM_Sel !== 1'b0 || oTimeout !== 1'b0 || oBusy !== 1'b0) begin
            errors++; $display("FAIL rst_mid got gnt1=%b sel=%b to=%b busy=%b required 0 0 0 0", oGnt1, oRAM_Sel, oTimeout, oBusy);
        end
        iRst = 1'b0; iReq1 = 1'b0;
        tick(2);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_missing got=%0d pending required=0", exp_q.size()); end
        $display("test_reset_mid_grant done");
    endtask

    task automatic test_random();
        sb_en = 1'b0;
        excl_en = 1'b1;
        iEn = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) iReq0 = ~iReq0;
            if ($urandom_range(0, 3) == 0) iReq1 = ~iReq1;
            iDone0 = ($urandom_range(0, 5) == 0);
            iDone1 = ($urandom_range(0, 5) == 0);
            iEn    = ($urandom_range(0, 7) != 0);
            tick(1);
        end
        iReq0 = 1'b0; iReq1 = 1'b0; iDone0 = 1'b0; iDone1 = 1'b0; iEn = 1'b1;
        tick(30);
        excl_en = 1'b0;
        checks++; if (oGnt0 !== 1'b0 || oGnt1 !== 1'b0 || oBusy !== 1'b0) begin
            errors++; $display("FAIL rand_settle got gnt0=%b gnt1=%b busy=%b required 0 0 0", oGnt0, oGnt1, oBusy);
        end
        $display("test_random done");
    endtask

    initial begin
        tick(1);
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_enable();
        test_abandon();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
